// File: rtl/ddr3_pattern_checker.sv
// Drains readback beats from the output FIFO, regenerates the counter/LFSR write pattern and
// accumulates per-run pass/fail statistics for the host status registers.
module ddr3_pattern_checker #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned LANES      = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_mode,
  input  logic [31:0]           i_seed,
  input  logic [CNT_WIDTH-1:0]  i_num_beats,
  output logic                  o_ob_re,
  input  logic [DATA_WIDTH-1:0] i_ob_rdata,
  input  logic                  i_ob_valid,
  input  logic                  i_ob_empty,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_aborted,
  output logic [CNT_WIDTH-1:0]  o_beats_checked,
  output logic [CNT_WIDTH-1:0]  o_err_beats,
  output logic [CNT_WIDTH-1:0]  o_err_bits,
  output logic [CNT_WIDTH-1:0]  o_first_err_beat,
  output logic [LANES-1:0]      o_first_err_lanes
);

  localparam int unsigned PcW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                r_state, w_state_d;
  logic                  r_mode;
  logic [CNT_WIDTH-1:0]  r_num_beats, r_issued;
  logic                  r_outstanding;
  logic [31:0]           r_pat;
  logic                  r_cmp_valid;
  logic [DATA_WIDTH-1:0] r_xor;
  logic [CNT_WIDTH-1:0]  r_beats_checked, r_err_beats, r_err_bits, r_first_err_beat;
  logic [LANES-1:0]      r_first_err_lanes;
  logic                  r_done, r_aborted;

  logic                  w_ob_re, w_start_ok, w_active, w_accept;
  logic [DATA_WIDTH-1:0] w_expected;
  logic [31:0]           w_lfsr, w_pat_next;
  logic [LANES-1:0]      w_lane_err;
  logic [PcW-1:0]        w_popcnt;
  logic [CNT_WIDTH:0]    w_bits_sum;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  assign w_active   = (r_state == StRun) || (r_state == StDrain);
  assign w_start_ok = i_start && ((r_state == StIdle) || (r_state == StDone));
  assign w_accept   = i_ob_valid && w_active;

  always_comb begin
    w_state_d = r_state;
    w_ob_re   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_d = (i_num_beats == '0) ? StDone : StRun;
      end
      StRun: begin
        if (i_abort) begin
          w_state_d = StDrain;
        end else begin
          w_ob_re = !i_ob_empty && (r_issued < r_num_beats);
          if ((r_issued >= r_num_beats) ||
              (w_ob_re && (r_issued + CNT_WIDTH'(1) == r_num_beats))) begin
            w_state_d = StDrain;
          end
        end
      end
      // Wait for both the in-flight read and the compare stage so results are final at done.
      StDrain: begin
        if (!r_outstanding && !r_cmp_valid) w_state_d = StDone;
      end
      StDone: begin
        if (i_start) w_state_d = (i_num_beats == '0) ? StDone : StRun;
        else         w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_expected = '0;
    w_lfsr     = r_pat;
    for (int k = 0; k < LANES; k++) begin
      if (r_mode) begin
        w_expected[k*32 +: 32] = w_lfsr;
        w_lfsr                 = lfsr_step(w_lfsr);
      end else begin
        w_expected[k*32 +: 32] = r_pat + 32'(k);
      end
    end
    w_pat_next = r_mode ? w_lfsr : r_pat + 32'(LANES);
  end

  always_comb begin
    w_popcnt   = '0;
    w_lane_err = '0;
    for (int i = 0; i < DATA_WIDTH; i++) w_popcnt = w_popcnt + PcW'(r_xor[i]);
    for (int k = 0; k < LANES; k++) w_lane_err[k] = |r_xor[k*32 +: 32];
    w_bits_sum = {1'b0, r_err_bits} + (CNT_WIDTH+1)'(w_popcnt);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state           <= StIdle;
      r_mode            <= 1'b0;
      r_num_beats       <= '0;
      r_issued          <= '0;
      r_outstanding     <= 1'b0;
      r_pat             <= '0;
      r_cmp_valid       <= 1'b0;
      r_xor             <= '0;
      r_beats_checked   <= '0;
      r_err_beats       <= '0;
      r_err_bits        <= '0;
      r_first_err_beat  <= '0;
      r_first_err_lanes <= '0;
      r_done            <= 1'b0;
      r_aborted         <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_start_ok) begin
        r_mode            <= i_mode;
        r_num_beats       <= i_num_beats;
        r_pat             <= (i_mode && (i_seed == '0)) ? 32'h0000_0001 : i_seed;
        r_issued          <= '0;
        r_outstanding     <= 1'b0;
        r_cmp_valid       <= 1'b0;
        r_beats_checked   <= '0;
        r_err_beats       <= '0;
        r_err_bits        <= '0;
        r_first_err_beat  <= '0;
        r_first_err_lanes <= '0;
        r_done            <= 1'b0;
        r_aborted         <= 1'b0;
      end else begin
        if (w_ob_re) r_issued <= r_issued + CNT_WIDTH'(1);
        r_outstanding <= w_ob_re | (r_outstanding & ~w_accept);
        r_cmp_valid   <= w_accept;
        if (w_accept) begin
          r_xor <= i_ob_rdata ^ w_expected;
          r_pat <= w_pat_next;
        end
        if (r_cmp_valid) begin
          r_beats_checked <= r_beats_checked + CNT_WIDTH'(1);
          if (|w_lane_err) begin
            if (r_err_beats != '1) r_err_beats <= r_err_beats + CNT_WIDTH'(1);
            r_err_bits <= w_bits_sum[CNT_WIDTH] ? '1 : w_bits_sum[CNT_WIDTH-1:0];
            if (r_err_beats == '0) begin
              r_first_err_beat  <= r_beats_checked;
              r_first_err_lanes <= w_lane_err;
            end
          end
        end
        if (w_active && i_abort) r_aborted <= 1'b1;
      end
      if (w_state_d == StDone) r_done <= 1'b1;
    end
  end

  assign o_ob_re           = w_ob_re;
  assign o_busy            = w_active;
  assign o_done            = r_done;
  assign o_pass            = r_done && (r_err_beats == '0) && !r_aborted;
  assign o_aborted         = r_aborted;
  assign o_beats_checked   = r_beats_checked;
  assign o_err_beats       = r_err_beats;
  assign o_err_bits        = r_err_bits;
  assign o_first_err_beat  = r_first_err_beat;
  assign o_first_err_lanes = r_first_err_lanes;

endmodule

// File: tb/tb_ddr3_pattern_checker.sv
// Bench for ddr3_pattern_checker: FIFO model, table-driven runs, randomized runs against a
// word-level pattern model, plus abort, zero-length, spurious-valid and mid-run reset sequences.
module tb_ddr3_pattern_checker;
  localparam int unsigned DW = 256;
  localparam int unsigned L  = 8;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          reset, start, abort, mode;
  logic [31:0]   seed;
  logic [CW-1:0] num_beats;
  logic          ob_re, ob_valid, ob_empty;
  logic [DW-1:0] ob_rdata;
  logic          busy, done, pass, aborted;
  logic [CW-1:0] beats_checked, err_beats, err_bits, first_err_beat;
  logic [L-1:0]  first_err_lanes;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO model state: main thread appends to fifo_mem, the FIFO process owns the read side.
  logic [DW-1:0] fifo_mem[$];
  int            rd_ptr, re_count, re_while_empty, spur_seen, flush_seen;
  logic          pend, gate;
  logic [DW-1:0] pend_data;
  bit            stall_en = 1'b0;
  int            spur_cnt = 0;
  int            flush_cnt = 0;

  always #5 clk = ~clk;

  ddr3_pattern_checker #(.DATA_WIDTH(DW), .LANES(L), .CNT_WIDTH(CW)) u_dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_start          (start),
    .i_abort          (abort),
    .i_mode           (mode),
    .i_seed           (seed),
    .i_num_beats      (num_beats),
    .o_ob_re          (ob_re),
    .i_ob_rdata       (ob_rdata),
    .i_ob_valid       (ob_valid),
    .i_ob_empty       (ob_empty),
    .o_busy           (busy),
    .o_done           (done),
    .o_pass           (pass),
    .o_aborted        (aborted),
    .o_beats_checked  (beats_checked),
    .o_err_beats      (err_beats),
    .o_err_bits       (err_bits),
    .o_first_err_beat (first_err_beat),
    .o_first_err_lanes(first_err_lanes)
  );

  initial begin
    ob_valid = 1'b0; ob_rdata = '0; ob_empty = 1'b1;
    rd_ptr = 0; pend = 1'b0; pend_data = '0; gate = 1'b0;
    re_count = 0; re_while_empty = 0; spur_seen = 0; flush_seen = 0;
    forever begin
      @(negedge clk);
      if (flush_cnt != flush_seen) begin
        flush_seen = flush_cnt;
        rd_ptr     = fifo_mem.size();
      end
      ob_valid  = pend || (spur_cnt != spur_seen);
      ob_rdata  = pend ? pend_data : {L{32'hDEAD_BEEF}};
      spur_seen = spur_cnt;
      pend      = 1'b0;
      gate      = stall_en ? ~gate : 1'b0;
      ob_empty  = (rd_ptr >= fifo_mem.size()) || gate;
      #4;
      if (ob_re && !reset) begin
        re_count++;
        if (ob_empty) begin
          re_while_empty++;
        end else begin
          pend      = 1'b1;
          pend_data = fifo_mem[rd_ptr];
          rd_ptr++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // Word n of the stream (n = beat*LANES + lane), straight from the pattern definition.
  function automatic logic [31:0] exp_word(input bit m, input logic [31:0] sd, input int n);
    logic [31:0] s;
    if (!m) return sd + 32'(n);
    s = (sd == 32'h0) ? 32'h1 : sd;
    for (int i = 0; i < n; i++) s = step(s);
    return s;
  endfunction

  function automatic logic [DW-1:0] exp_beat(input bit m, input logic [31:0] sd, input int b);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < int'(L); k++) r[k*32 +: 32] = exp_word(m, sd, b * int'(L) + k);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_run(input bit m, input logic [31:0] sd, input int nb,
                        input logic [DW-1:0] beats[$], input bit stall, input string tag);
    int cyc;
    foreach (beats[i]) fifo_mem.push_back(beats[i]);
    stall_en = stall;
    @(negedge clk);
    mode = m; seed = sd; num_beats = CW'(nb); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (nb > 0) check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!(done && !busy) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_finished"}, 32'(cyc < 2000), 32'd1);
    stall_en = 1'b0;
  endtask

  task automatic check_results(input string tag, input int xc, input int xeb, input int xbits,
                               input int xfb, input logic [7:0] xfl, input bit xpass,
                               input bit xab);
    check({tag, "_beats_checked"}, beats_checked, 32'(xc));
    check({tag, "_err_beats"}, err_beats, 32'(xeb));
    check({tag, "_err_bits"}, err_bits, 32'(xbits));
    check({tag, "_first_err_beat"}, first_err_beat, 32'(xfb));
    check({tag, "_first_err_lanes"}, 32'(first_err_lanes), 32'(xfl));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_pass"}, 32'(pass), 32'(xpass));
    check({tag, "_aborted"}, 32'(aborted), 32'(xab));
  endtask

  typedef struct {
    bit          m;
    logic [31:0] sd;
    int          nb;
    bit          stall;
    int          bad_beat;
    int          bad_lane;
    logic [31:0] bad_xor;
    int          pin_lane;
    logic [31:0] pin_val;
    int          x_checked;
    int          x_errb;
    int          x_errbits;
    int          x_fbeat;
    logic [7:0]  x_flanes;
    bit          x_pass;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [DW-1:0] bq[$];
    logic [DW-1:0] d, e, x;
    logic [7:0]    fl;
    int            nb, eb, ebits, fb, cyc, re0, last_nb;
    bit            m;
    logic [31:0]   sd;

    // Pinned lanes carry hand-derived expected words; other lanes come from the model.
    vecs[0] = '{1'b0, 32'h0, 4, 1'b0, -1, 0, 32'h0, -1, 32'h0, 4, 0, 0, 0, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 32'h0, 4, 1'b0, 2, 5, 32'hF, -1, 32'h0, 4, 1, 4, 2, 8'b0010_0000, 1'b0};
    vecs[2] = '{1'b1, 32'h0, 1, 1'b0, -1, 0, 32'h0, 0, 32'h1, 1, 0, 0, 0, 8'h00, 1'b1};
    vecs[3] = '{1'b1, 32'h0, 1, 1'b0, -1, 0, 32'h0, 1, 32'h3, 1, 0, 0, 0, 8'h00, 1'b1};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 1, 1'b0, -1, 0, 32'h0, 4, 32'h0, 1, 0, 0, 0, 8'h00, 1'b1};
    vecs[5] = '{1'b0, 32'h0, 8, 1'b1, -1, 0, 32'h0, -1, 32'h0, 8, 0, 0, 0, 8'h00, 1'b1};
    vecs[6] = '{1'b1, 32'h1234_5678, 3, 1'b0, 0, 0, 32'hFFFF_FFFF, -1, 32'h0,
                3, 1, 32, 0, 8'h01, 1'b0};
    vecs[7] = '{1'b0, 32'd100, 5, 1'b1, 4, 7, 32'h8000_0001, -1, 32'h0,
                5, 1, 2, 4, 8'h80, 1'b0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; seed = '0; num_beats = '0;
    repeat (3) @(negedge clk);
    check("rst_ob_re", 32'(ob_re), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_beats_checked", beats_checked, 32'd0);
    check("rst_err_beats", err_beats, 32'd0);
    check("rst_err_bits", err_bits, 32'd0);
    check("rst_first_err_beat", first_err_beat, 32'd0);
    check("rst_first_err_lanes", 32'(first_err_lanes), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      bq.delete();
      for (int b = 0; b < vecs[i].nb; b++) begin
        d = exp_beat(vecs[i].m, vecs[i].sd, b);
        if (b == vecs[i].bad_beat) d[vecs[i].bad_lane*32 +: 32] ^= vecs[i].bad_xor;
        if (b == 0 && vecs[i].pin_lane >= 0) d[vecs[i].pin_lane*32 +: 32] = vecs[i].pin_val;
        bq.push_back(d);
      end
      do_run(vecs[i].m, vecs[i].sd, vecs[i].nb, bq, vecs[i].stall, $sformatf("vec%0d", i));
      check_results($sformatf("vec%0d", i), vecs[i].x_checked, vecs[i].x_errb,
                    vecs[i].x_errbits, vecs[i].x_fbeat, vecs[i].x_flanes, vecs[i].x_pass, 1'b0);
    end

    last_nb = 0;
    for (int r = 0; r < 6; r++) begin
      m = 1'($urandom_range(0, 1));
      sd = $urandom;
      nb = $urandom_range(1, 10);
      bq.delete();
      eb = 0; ebits = 0; fb = 0; fl = '0;
      for (int b = 0; b < nb; b++) begin
        e = exp_beat(m, sd, b);
        d = e;
        if ($urandom_range(0, 2) == 0) d[$urandom_range(0, 7)*32 +: 32] ^= ($urandom | 32'h1);
        if ($urandom_range(0, 4) == 0) d[$urandom_range(0, 7)*32 +: 32] ^= ($urandom | 32'h1);
        bq.push_back(d);
        x = d ^ e;
        if (x != '0) begin
          if (eb == 0) begin
            fb = b;
            for (int k = 0; k < int'(L); k++) fl[k] = |x[k*32 +: 32];
          end
          eb++;
          ebits += $countones(x);
        end
      end
      do_run(m, sd, nb, bq, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
      check_results($sformatf("rnd%0d", r), nb, eb, ebits, fb, fl, (eb == 0), 1'b0);
      last_nb = nb;
    end

    // A stray valid outside a run must not touch the results.
    spur_cnt++;
    repeat (4) @(negedge clk);
    check("spurious_beats_checked", beats_checked, 32'(last_nb));
    check("spurious_done", 32'(done), 32'd1);

    bq.delete();
    for (int b = 0; b < 16; b++) fifo_mem.push_back(exp_beat(1'b0, 32'h0, b));
    re0 = re_count;
    @(negedge clk);
    mode = 1'b0; seed = 32'h0; num_beats = 32'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while ((re_count - re0) < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_5_reads", 32'(cyc < 200), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    cyc = 0;
    while (!(done && !busy) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_finished", 32'(cyc < 200), 32'd1);
    check("abort_aborted", 32'(aborted), 32'd1);
    check("abort_done", 32'(done), 32'd1);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_err_beats", err_beats, 32'd0);
    check("abort_checked_5_to_6", 32'(beats_checked >= 5 && beats_checked <= 6), 32'd1);
    flush_cnt++;
    repeat (2) @(negedge clk);

    bq.delete();
    do_run(1'b0, 32'h0, 0, bq, 1'b0, "zero");
    check_results("zero", 0, 0, 0, 0, 8'h00, 1'b1, 1'b0);

    for (int b = 0; b < 10; b++) fifo_mem.push_back(exp_beat(1'b1, 32'h55, b));
    stall_en = 1'b1;
    @(negedge clk);
    mode = 1'b1; seed = 32'h55; num_beats = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ob_re", 32'(ob_re), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_beats_checked", beats_checked, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    stall_en = 1'b0;
    flush_cnt++;
    repeat (2) @(negedge clk);

    bq.delete();
    for (int b = 0; b < 2; b++) bq.push_back(exp_beat(1'b1, 32'h77, b));
    do_run(1'b1, 32'h77, 2, bq, 1'b0, "post_rst");
    check_results("post_rst", 2, 0, 0, 0, 8'h00, 1'b1, 1'b0);

    check("re_while_empty", 32'(re_while_empty), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ddr3_pattern_checker.md
Name: ddr3_pattern_checker

Overview:
- Downstream consumer of the DDR3 test engine's output buffer: drains 256-bit readback beats from the output FIFO read port.
- Regenerates the expected write pattern (counter or LFSR-32) and compares it per 32-bit lane.
- Reports pass/fail, error counts and first-failure location to the host control/status registers.
- Sits between the output FIFO and the host status interface in the RAM tester.

Parameters:
- DATA_WIDTH, 256, beat width; must equal LANES*32.
- LANES, 8, number of 32-bit words per beat.
- CNT_WIDTH, 32, width of beat and error counters.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; latches mode, seed and num_beats, clears results, begins a run.
- abort  in  1  one-cycle pulse; ends a run early.
- mode  in  1  0 = counter pattern, 1 = LFSR-32 pattern.
- seed  in  32  pattern seed.
- num_beats  in  CNT_WIDTH  beats to check in this run.
- ob_re  out  1  output FIFO read enable.
- ob_rdata  in  DATA_WIDTH  FIFO read data; lane k = bits [32k+31:32k].
- ob_valid  in  1  high exactly one cycle after an accepted ob_re.
- ob_empty  in  1  FIFO empty.
- busy  out  1  run in progress.
- done  out  1  sticky; set at end of run, cleared by start or reset.
- pass  out  1  done && err_beats==0 && !aborted.
- aborted  out  1  sticky; run ended by abort.
- beats_checked  out  CNT_WIDTH  beats compared so far.
- err_beats  out  CNT_WIDTH  beats with ≥1 mismatching lane; saturates at all-ones.
- err_bits  out  CNT_WIDTH  total mismatching bits (popcount of XOR); saturates.
- first_err_beat  out  CNT_WIDTH  index of first failing beat.
- first_err_lanes  out  LANES  lane-mismatch mask of first failing beat.

Behaviour:
- Reset values:
  - ob_re, busy, done, pass, aborted = 0.
  - All counters, first_err_beat and first_err_lanes = 0.
  - FSM in IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch inputs, clear results, go to RUN. If num_beats==0, go straight to DONE, which sets done=1 and pass=1 the next cycle.
  - RUN: ob_re=1 in a cycle iff !ob_empty && issued<num_beats && !abort. Back-to-back reads are allowed. When issued reaches num_beats, go to DRAIN.
  - DRAIN: wait until outstanding==0, then go to DONE.
  - abort in RUN: stop issuing, set aborted, go to DRAIN.
  - abort in DRAIN: sets aborted only.
  - DONE: done=1, busy=0; go to IDLE next cycle, keeping done and results.
  - busy=1 in RUN and DRAIN.
- start while busy is ignored.
- start in DONE or IDLE begins a new run.
- Outstanding reads = issued − received. It is at most 1, given the one-cycle valid latency.
- Comparison, on each ob_valid:
  - Compare lane k against expected E[k] and increment beats_checked.
  - On mismatch, err_beats += 1 and err_bits += popcount(ob_rdata ^ expected), both saturating.
  - On the first mismatch only, capture first_err_beat = beats_checked (pre-increment) and the lane mask.
  - Comparison and counter update complete in the cycle after ob_valid (1-stage register pipeline). done must not assert before the last beat's update lands.
- Counter pattern:
  - E[k] = seed + LANES*b + k, modulo 2^32, where b = beat index.
  - Implement as a running base incremented by LANES per beat.
- LFSR pattern:
  - step(s) = {s[30:0], s[31]^s[21]^s[1]^s[0]}.
  - E[0] = state; E[k] = step^k(state); next state = step^LANES(state).
  - Initial state = seed, with 0 replaced by 32'h00000001.
- Pattern state advances only on ob_valid. FIFO stalls (ob_empty) do not advance it.
- ob_valid arriving in IDLE or DONE is ignored: no counter change.
- Reset asserted mid-run returns the block immediately to reset values. FIFO contents are not flushed.

Test Plan:
- Counter mode, seed=0, num_beats=4, FIFO loaded with correct data → beat n lane k = 8n+k; beats_checked=4, err_beats=0, done=1, pass=1.
- Counter mode, seed=0, num_beats=4, beat 2 lane 5 bits [3:0] flipped → err_beats=1, err_bits=4, first_err_beat=2, first_err_lanes=8'b00100000, pass=0.
- LFSR mode, seed=0, num_beats=1, correct data → E[0]=32'h00000001, E[1]=32'h00000003; pass=1.
- Counter mode, seed=32'hFFFFFFFC, num_beats=1 → lane 4 expected 32'h00000000 (wrap); pass=1.
- ob_empty toggled every other cycle during 8-beat run → ob_re never high while ob_empty; all 8 beats checked; pass=1.
- num_beats=16, abort after 5 beats → aborted=1, done=1, pass=0, beats_checked≤6. A second start with num_beats=0 → done=1, pass=1, aborted=0.
